// File: rtl/tt3_vector_sequencer.sv
// tt3_vector_sequencer: walks {a,b,y} through 0..7, samples good_in after a settle window, counts mismatches.
// Latency: SETTLE_CYC+1 cycles per vector; DONE is entered 8*(SETTLE_CYC+1) edges after the start-accept edge.
// Backpressure: none; start is only honoured in IDLE and is dropped (not queued) while busy or in DONE.
//
// Optional build macro TT3_FIRST_ERR_CAPTURE_EN adds first_err_vld/first_err_idx, which record the
// first mismatching vector of a run.
//
// Parameters:
//   SETTLE_CYC : cycles a vector is held before its sample cycle (1..15).
//   EXPECT     : expected good_in per vector; bit i applies to {a,b,y} == i.

module tt3_vector_sequencer #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [7:0]  EXPECT     = 8'h96
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       good_in,
    output logic       a,
    output logic       b,
    output logic       y,
    output logic [2:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt
`ifdef TT3_FIRST_ERR_CAPTURE_EN
    ,
    output logic       first_err_vld,
    output logic [2:0] first_err_idx
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Last value of the settle counter before moving on to the sample cycle.
    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       mismatch;

    // Compare the checker output against the truth table for the vector on the pins.
    assign mismatch = (good_in != EXPECT[vec_idx]);

    // Sequencer FSM: every output is registered here, so good_in only reaches err_cnt via a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            a       <= 1'b0;
            b       <= 1'b0;
            y       <= 1'b0;
            vec_idx <= 3'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= 4'd0;
        end else begin
            // done is a single-cycle pulse; only the SAMPLE->DONE transition raises it.
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SETTLE;
                        vec_idx   <= 3'd0;
                        {a, b, y} <= 3'b000;
                        err_cnt   <= 4'd0;
                        pass      <= 1'b0;
                        cnt       <= 4'd0;
                        busy      <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 4'd1;
                    end
                    // Vector 7 is terminal: a, b, y and vec_idx stay at 7 until the next start.
                    if (vec_idx == 3'd7) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        vec_idx   <= vec_idx + 3'd1;
                        {a, b, y} <= vec_idx + 3'd1;
                        cnt       <= 4'd0;
                        state     <= SETTLE;
                    end
                end
                DONE: begin
                    // err_cnt already includes the vector-7 result by the time DONE is reached.
                    pass  <= (err_cnt == 4'd0);
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef TT3_FIRST_ERR_CAPTURE_EN
    // Capture the index of the first mismatch of a run; sticky until the next accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_err_vld <= 1'b0;
            first_err_idx <= 3'd0;
        end else if (state == IDLE && start) begin
            first_err_vld <= 1'b0;
            first_err_idx <= 3'd0;
        end else if (state == SAMPLE && mismatch && !first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_idx <= vec_idx;
        end
    end
`endif

endmodule

// File: tb/tb_tt3_vector_sequencer.sv
// tb_tt3_vector_sequencer: drives runs of the vector sequencer against a modelled checker.
// Two instances: default SETTLE_CYC=2 and SETTLE_CYC=1; one is selected per run.
// Expected run results are queued at start and popped when done pulses.

module tb_tt3_vector_sequencer;

    typedef struct packed {
        logic [3:0] err;
        logic       pass;
        logic       fvld;
        logic [2:0] fidx;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       sel;
    logic [7:0] exp_tt;
    logic [7:0] fault_mask;
    logic       glitch_now;

    logic       start0, start1, good0, good1;
    logic       a0, b0, y0, busy0, done0, pass0;
    logic       a1, b1, y1, busy1, done1, pass1;
    logic [2:0] idx0, idx1;
    logic [3:0] err0, err1;
`ifdef TT3_FIRST_ERR_CAPTURE_EN
    logic       fv0, fv1;
    logic [2:0] fi0, fi1;
    logic       m_fv;
    logic [2:0] m_fi;
`endif

    logic [2:0] m_abc, m_idx;
    logic [3:0] m_err;
    logic       m_busy, m_done, m_pass;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    // Checker model: good follows the expected truth table unless a fault or glitch is injected.
    assign good0  = exp_tt[{a0, b0, y0}] ^ fault_mask[{a0, b0, y0}] ^ glitch_now;
    assign good1  = exp_tt[{a1, b1, y1}] ^ fault_mask[{a1, b1, y1}] ^ glitch_now;
    assign start0 = start & ~sel;
    assign start1 = start & sel;

    assign m_abc  = sel ? {a1, b1, y1} : {a0, b0, y0};
    assign m_idx  = sel ? idx1 : idx0;
    assign m_err  = sel ? err1 : err0;
    assign m_busy = sel ? busy1 : busy0;
    assign m_done = sel ? done1 : done0;
    assign m_pass = sel ? pass1 : pass0;
`ifdef TT3_FIRST_ERR_CAPTURE_EN
    assign m_fv   = sel ? fv1 : fv0;
    assign m_fi   = sel ? fi1 : fi0;
`endif

    tt3_vector_sequencer #(.SETTLE_CYC(2), .EXPECT(8'h96)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .good_in(good0),
        .a(a0), .b(b0), .y(y0), .vec_idx(idx0), .busy(busy0), .done(done0),
        .pass(pass0), .err_cnt(err0)
`ifdef TT3_FIRST_ERR_CAPTURE_EN
        , .first_err_vld(fv0), .first_err_idx(fi0)
`endif
    );

    tt3_vector_sequencer #(.SETTLE_CYC(1), .EXPECT(8'h96)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .good_in(good1),
        .a(a1), .b(b1), .y(y1), .vec_idx(idx1), .busy(busy1), .done(done1),
        .pass(pass1), .err_cnt(err1)
`ifdef TT3_FIRST_ERR_CAPTURE_EN
        , .first_err_vld(fv1), .first_err_idx(fi1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One run: s selects the instance, fmask inverts good for the flagged vectors, glitch inverts
    // good only in the first cycle of each vector, restart_k re-pulses start k cycles after accept,
    // abort_k asserts reset k cycles after accept.
    task automatic run_seq(input bit s, input logic [7:0] fmask, input bit glitch,
                           input int restart_k, input int abort_k);
        int   per;
        int   total;
        int   nerr;
        int   fidx;
        exp_t e;
        per  = s ? 2 : 3;
        total = 8 * per;
        nerr = 0;
        fidx = -1;
        for (int v = 0; v < 8; v++) begin
            if (fmask[v]) begin
                nerr++;
                if (fidx < 0) fidx = v;
            end
        end
        e.err  = 4'(nerr);
        e.pass = (nerr == 0);
        e.fvld = (fidx >= 0);
        e.fidx = (fidx >= 0) ? 3'(fidx) : 3'd0;
        sb_q.push_back(e);

        sel        = s;
        fault_mask = fmask;
        start      = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= total + 1; k++) begin
            @(negedge clk);
            start      = (k == restart_k);
            glitch_now = glitch && (k < total) && ((k % per) == 0);
            if (k == abort_k) begin
                reset = 1'b1;
                #1;
                chk("abort_abc",  32'(m_abc),  0);
                chk("abort_idx",  32'(m_idx),  0);
                chk("abort_busy", 32'(m_busy), 0);
                chk("abort_done", 32'(m_done), 0);
                chk("abort_err",  32'(m_err),  0);
                chk("abort_pass", 32'(m_pass), 0);
                void'(sb_q.pop_front());
                @(negedge clk);
                reset      = 1'b0;
                start      = 1'b0;
                glitch_now = 1'b0;
                return;
            end
            if (k < total) begin
                chk("busy",    32'(m_busy), 1);
                chk("done_lo", 32'(m_done), 0);
                chk("vec_idx", 32'(m_idx),  32'(k / per));
                chk("abc",     32'(m_abc),  32'(k / per));
                if (k == 0) begin
                    chk("err_clr",  32'(m_err),  0);
                    chk("pass_clr", 32'(m_pass), 0);
                end
            end else if (k == total) begin
                chk("done",    32'(m_done), 1);
                chk("busy_lo", 32'(m_busy), 0);
                e = sb_q.pop_front();
                chk("err_cnt", 32'(m_err), 32'(e.err));
`ifdef TT3_FIRST_ERR_CAPTURE_EN
                chk("ferr_vld", 32'(m_fv), 32'(e.fvld));
                if (e.fvld) chk("ferr_idx", 32'(m_fi), 32'(e.fidx));
`endif
            end else begin
                chk("done_end", 32'(m_done), 0);
                chk("busy_end", 32'(m_busy), 0);
                chk("pass",     32'(m_pass), 32'(e.pass));
                chk("hold_idx", 32'(m_idx),  7);
                chk("hold_abc", 32'(m_abc),  7);
            end
        end
        glitch_now = 1'b0;
        start      = 1'b0;
    endtask

    initial begin
        exp_tt     = 8'h96;
        reset      = 1'b1;
        start      = 1'b0;
        sel        = 1'b0;
        fault_mask = 8'h00;
        glitch_now = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_abc",  32'({a0, b0, y0}), 0);
        chk("rst_idx",  32'(idx0),  0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_pass", 32'(pass0), 0);
        chk("rst_err",  32'(err0),  0);
        reset = 1'b0;
        @(negedge clk);

        run_seq(1'b0, 8'h00, 1'b0, -1, -1);   // correct checker
        run_seq(1'b0, 8'hFF, 1'b0, -1, -1);   // fully inverted checker
        run_seq(1'b0, 8'h20, 1'b0, -1, -1);   // vector 5 wrong
        run_seq(1'b0, 8'h00, 1'b0, -1, -1);   // clean rerun clears the result
        run_seq(1'b0, 8'h00, 1'b0,  9, -1);   // start re-pulsed during vector 3
        run_seq(1'b0, 8'h01, 1'b0, -1, 12);   // reset during SETTLE of vector 4
        run_seq(1'b0, 8'h00, 1'b0, -1, -1);   // full run after the abort

        // start held across an edge where reset is still high must not launch a run
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", 32'(busy0), 0);
        chk("rst_start_idle", 32'(busy1), 0);

        run_seq(1'b1, 8'h00, 1'b1, -1, -1);   // SETTLE_CYC=1, glitch in settle cycle only
        run_seq(1'b1, 8'h80, 1'b0, -1, -1);   // SETTLE_CYC=1, only vector 7 wrong

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt3_vector_sequencer.md
Name: tt3_vector_sequencer

Overview:
- FSM controller for the 3-input `good` checker datapath (inputs a, b, y; output good).
- On `start` it drives all 8 input combinations {a,b,y} = 0..7 in order.
- For each vector it waits a settle window, samples `good`, and compares it with an expected truth table.
- It counts mismatches and reports pass/fail, replacing free-running toggle stimulus with a self-checking sequence.

Parameters:
- SETTLE_CYC, 2, cycles a vector is held before the sample cycle; legal range 1..15.
- EXPECT, 8'h96, expected `good` per vector; bit i is the expected value for {a,b,y} == i.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- start  input  1  run request; sampled only in IDLE.
- good_in  input  1  checker output under test.
- a  output  1  vector bit 2 (MSB of idx).
- b  output  1  vector bit 1.
- y  output  1  vector bit 0.
- vec_idx  output  3  index of the vector currently driven.
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  one-cycle pulse in the DONE state.
- pass  output  1  1 if the last run had zero mismatches; held until the next accepted start.
- err_cnt  output  4  mismatch count for the current or last run (0..8).

Behaviour:
- Reset values: state=IDLE; a=b=y=0; vec_idx=0; busy=0; done=0; pass=0; err_cnt=0; settle counter=0.
- Outputs are registered; there is no combinational path from good_in to any output.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1:
  - next state SETTLE; vec_idx<=0; {a,b,y}<=3'b000; err_cnt<=0; pass<=0; cnt<=0.
- IDLE, start=0: stay in IDLE; outputs hold.
- SETTLE:
  - if cnt==SETTLE_CYC-1, go to SAMPLE; otherwise cnt<=cnt+1.
  - {a,b,y} are stable for the whole SETTLE+SAMPLE span of a vector.
- SAMPLE (exactly one cycle):
  - at the closing edge, if good_in != EXPECT[vec_idx], then err_cnt<=err_cnt+1.
  - if vec_idx==7, go to DONE.
  - otherwise vec_idx<=vec_idx+1, {a,b,y}<=vec_idx+1, cnt<=0, go to SETTLE.
  - vec_idx does not wrap: 7 is terminal.
- DONE (one cycle):
  - done=1; pass<=(err_cnt==0) using the final count, including the vector-7 result; next state IDLE.
  - a, b, y and vec_idx hold their last values (vector 7) until the next start.
- Timing per vector: SETTLE_CYC+1 cycles. DONE is entered 8*(SETTLE_CYC+1) edges after the start-accept edge (24 edges at default).
- busy=1 from the edge after start acceptance through the last SAMPLE cycle; busy=0 in DONE and IDLE.
- start is ignored while busy=1 and during DONE; no queuing.
- err_cnt maximum is 8, so 4 bits never overflow; no saturation logic.
- Reset asserted mid-run forces the reset values immediately, asynchronously. Deasserting reset leaves the block in IDLE; the aborted run is not resumed.
- A start and a reset deassertion on the same edge: start is ignored until the first edge with reset low.

Optional Feature:
- Macro: TT3_FIRST_ERR_CAPTURE_EN.
- When defined, adds two outputs:
  - first_err_vld (1 bit): cleared on start accept and on reset; set on the first mismatch of a run.
  - first_err_idx (3 bits): captures vec_idx on that first mismatch.
  - Both are sticky for the rest of the run and hold after DONE until the next start accept.
- When undefined, neither port exists and no capture logic is built. All other behaviour is identical.

Test Plan:
- Model good=EXPECT[{a,b,y}], pulse start, SETTLE_CYC=2 -> vectors 0..7 each held 3 cycles; done pulses at edge 24 after accept; pass=1, err_cnt=0.
- Model good=~EXPECT[{a,b,y}] -> err_cnt=8, pass=0; with TT3_FIRST_ERR_CAPTURE_EN, first_err_vld=1 and first_err_idx=0.
- Model correct except vector 5 inverted -> err_cnt=1, pass=0, first_err_idx=5; a second run with the correct model -> err_cnt=0, pass=1, first_err_vld=0.
- Pulse start again while busy at vector 3 -> ignored: sequence continues to 7, exactly one done pulse, total 24 cycles.
- Assert reset during SETTLE of vector 4 -> a=b=y=0, busy=0, err_cnt=0, pass=0 immediately; new start after release runs a full 24-cycle sequence.
- SETTLE_CYC=1 -> each vector held 2 cycles; done at edge 16 after accept; good_in glitch only in the first cycle of a vector is not counted.
